// File: rtl/carry_chain_pipe_pkg.sv
// Shared defaults, segment-count helper and per-bit result type for the pipelined carry chain.
package carry_pkg;

    localparam int CARRY_SEG_DEF   = 4;
    localparam int CARRY_WIDTH_DEF = 32;

    // One bit of chain result; a segment result is a packed array of these.
    typedef struct packed {
        logic co;
        logic o;
    } carry_res_t;

    function automatic int carry_nseg(input int width, input int seg);
        return (seg > 0) ? (width / seg) : 0;
    endfunction

endpackage

// File: rtl/carry_chain_pipe_seg.sv
// Combinational SEG-bit carry ripple: the CARRY4/CARRY8 CO/O function over one segment.
module carry_seg
    import carry_pkg::*;
#(
    parameter int SEG = CARRY_SEG_DEF
) (
    input  logic           ci,
    input  logic [SEG-1:0] di,
    input  logic [SEG-1:0] s,
    output logic [SEG-1:0] co,
    output logic [SEG-1:0] o
);

    always_comb begin
        logic c;
        // NOTE: blocking assignments are required here so each loop iteration sees the carry just produced by the previous bit.
        c  = ci;
        // NOTE: every output gets a default before the loop so no path through this block can infer a latch.
        co = '0;
        o  = '0;
        for (int i = 0; i < SEG; i++) begin
            o[i]  = s[i] ^ c;
            co[i] = s[i] ? c : di[i];
            c     = co[i];
        end
    end

endmodule

// File: rtl/carry_chain_pipe.sv
// Pipelined WIDTH-bit carry chain, one register stage per SEG-bit segment, fixed latency NSEG.
// Optional signed-overflow flags are built when CARRY_CHAIN_OVF_EN is defined.
module carry_chain_pipe
    import carry_pkg::*;
#(
    parameter int WIDTH = CARRY_WIDTH_DEF,
    parameter int SEG   = CARRY_SEG_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic             IN_VLD,
    input  logic             CI,
    input  logic             CYINIT,
    input  logic [WIDTH-1:0] DI,
    input  logic [WIDTH-1:0] S,
`ifdef CARRY_CHAIN_OVF_EN
    input  logic             OVF_CLR,
    output logic             OVF,
    output logic             OVF_STICKY,
`endif
    output logic             OUT_VLD,
    output logic [WIDTH-1:0] CO,
    output logic [WIDTH-1:0] O,
    output logic             COUT
);

    localparam int NSEG = carry_nseg(WIDTH, SEG);

    if (!(SEG == 4 || SEG == 8) || (WIDTH < SEG) || (WIDTH % SEG != 0)) begin : g_bad_cfg
        $error("carry_chain_pipe: WIDTH must be a positive multiple of SEG, and SEG must be 4 or 8");
    end

    logic             c0;
    logic [NSEG-1:0]  vld_in;
    logic [NSEG-1:0]  vld_q, vld_d;
    logic             out_load;
    logic             seg_cin [NSEG];
    logic [WIDTH-1:0] co_pre, o_pre;
    logic [WIDTH-1:0] co_q, co_d, o_q, o_d;

    assign c0 = CI | CYINIT;

    // vld_in[k] is the valid bit arriving at stage k on the next enabled edge.
    assign vld_in   = NSEG'({vld_q, IN_VLD});
    assign out_load = CE & vld_in[NSEG-1];

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        logic [SEG-1:0]         di_k, s_k, co_k, o_k;
        logic [SEG-1:0]         co_pre_k, o_pre_k;
        carry_res_t [SEG-1:0]   res_k, res_pre_k;

        if (k == 0) begin : g_head
            assign di_k       = DI[SEG-1:0];
            assign s_k        = S[SEG-1:0];
            assign seg_cin[0] = c0;
        end else begin : g_skew
            logic [SEG-1:0] di_sh_q [k];
            logic [SEG-1:0] s_sh_q  [k];

            always_ff @(posedge CLK) begin
                if (RST) begin
                    // NOTE: skew/deskew arrays are reset too, so a flushed pipe carries no stale operands.
                    for (int i = 0; i < k; i++) begin
                        di_sh_q[i] <= '0;
                        s_sh_q[i]  <= '0;
                    end
                end else if (CE) begin
                    di_sh_q[0] <= DI[k*SEG +: SEG];
                    s_sh_q[0]  <= S[k*SEG +: SEG];
                    for (int i = 1; i < k; i++) begin
                        di_sh_q[i] <= di_sh_q[i-1];
                        s_sh_q[i]  <= s_sh_q[i-1];
                    end
                end
            end

            assign di_k = di_sh_q[k-1];
            assign s_k  = s_sh_q[k-1];
        end

        carry_seg #(.SEG(SEG)) u_seg (
            .ci (seg_cin[k]),
            .di (di_k),
            .s  (s_k),
            .co (co_k),
            .o  (o_k)
        );

        always_comb begin
            res_k = '0;
            for (int b = 0; b < SEG; b++) begin
                res_k[b].co = co_k[b];
                res_k[b].o  = o_k[b];
            end
        end

        if (k < NSEG - 1) begin : g_dsk
            carry_res_t [SEG-1:0] dsk_q [NSEG-1-k];
            logic                 cout_q;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    cout_q <= 1'b0;
                    for (int i = 0; i < NSEG - 1 - k; i++) begin
                        dsk_q[i] <= '0;
                    end
                end else if (CE) begin
                    cout_q   <= co_k[SEG-1];
                    dsk_q[0] <= res_k;
                    for (int i = 1; i < NSEG - 1 - k; i++) begin
                        dsk_q[i] <= dsk_q[i-1];
                    end
                end
            end

            assign seg_cin[k+1] = cout_q;
            assign res_pre_k    = dsk_q[NSEG-2-k];
        end else begin : g_last
            assign res_pre_k = res_k;
        end

        always_comb begin
            co_pre_k = '0;
            o_pre_k  = '0;
            for (int b = 0; b < SEG; b++) begin
                co_pre_k[b] = res_pre_k[b].co;
                o_pre_k[b]  = res_pre_k[b].o;
            end
        end

        assign co_pre[k*SEG +: SEG] = co_pre_k;
        assign o_pre[k*SEG +: SEG]  = o_pre_k;
    end

    // Results load only on valid slots, so bubbles leave the last result visible.
    always_comb begin
        vld_d = vld_q;
        co_d  = co_q;
        o_d   = o_q;
        if (CE) begin
            vld_d = vld_in;
        end
        if (out_load) begin
            co_d = co_pre;
            o_d  = o_pre;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_q <= '0;
            co_q  <= '0;
            o_q   <= '0;
        end else begin
            vld_q <= vld_d;
            co_q  <= co_d;
            o_q   <= o_d;
        end
    end

    assign OUT_VLD = vld_q[NSEG-1];
    assign CO      = co_q;
    assign O       = o_q;
    assign COUT    = co_q[WIDTH-1];

`ifdef CARRY_CHAIN_OVF_EN
    logic ovf_pre;
    logic ovf_q, ovf_d;
    logic sticky_q, sticky_d;

    assign ovf_pre = co_pre[WIDTH-1] ^ co_pre[WIDTH-2];

    // A new overflow outranks a simultaneous clear.
    always_comb begin
        ovf_d    = ovf_q;
        sticky_d = sticky_q;
        if (out_load) begin
            ovf_d = ovf_pre;
        end
        if (out_load && ovf_pre) begin
            sticky_d = 1'b1;
        end else if (CE && OVF_CLR) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            ovf_q    <= ovf_d;
            sticky_q <= sticky_d;
        end
    end

    assign OVF        = ovf_q;
    assign OVF_STICKY = sticky_q;
`endif

endmodule

// File: tb/tb_carry_chain_pipe.sv
// Directed self-checking bench for carry_chain_pipe at WIDTH=16, SEG=4 (latency 4).
module tb_carry_chain_pipe;

    localparam int W = 16;

    logic         CLK = 1'b0;
    logic         RST, CE, IN_VLD, CI, CYINIT;
    logic [W-1:0] DI, S;
    logic         OUT_VLD, COUT;
    logic [W-1:0] CO, O;
`ifdef CARRY_CHAIN_OVF_EN
    logic         OVF_CLR, OVF, OVF_STICKY;
`endif

    int n_pass  = 0;
    int n_total = 0;

    logic [W-1:0] last_co = '0;
    logic [W-1:0] last_o  = '0;

    always #5 CLK = ~CLK;

    carry_chain_pipe #(.WIDTH(W), .SEG(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .CE         (CE),
        .IN_VLD     (IN_VLD),
        .CI         (CI),
        .CYINIT     (CYINIT),
        .DI         (DI),
        .S          (S),
`ifdef CARRY_CHAIN_OVF_EN
        .OVF_CLR    (OVF_CLR),
        .OVF        (OVF),
        .OVF_STICKY (OVF_STICKY),
`endif
        .OUT_VLD    (OUT_VLD),
        .CO         (CO),
        .O          (O),
        .COUT       (COUT)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic ce, input logic vld, input logic [W-1:0] di,
                         input logic [W-1:0] s, input logic ci, input logic cyinit);
        CE     = ce;
        IN_VLD = vld;
        DI     = di;
        S      = s;
        CI     = ci;
        CYINIT = cyinit;
    endtask

    // Full-width combinational ripple reference.
    function automatic logic [2*W-1:0] ref_chain(input logic [W-1:0] di, input logic [W-1:0] s,
                                                 input logic c_in);
        logic         c;
        logic [W-1:0] co, o;
        c = c_in;
        for (int i = 0; i < W; i++) begin
            o[i]  = s[i] ^ c;
            co[i] = s[i] ? c : di[i];
            c     = co[i];
        end
        return {co, o};
    endfunction

    task automatic expect_beat(input string tag, input logic [W-1:0] di, input logic [W-1:0] s,
                               input logic c_in);
        logic [2*W-1:0] r;
        r       = ref_chain(di, s, c_in);
        last_co = r[2*W-1:W];
        last_o  = r[W-1:0];
        check({tag, "/vld"},  W'(OUT_VLD), W'(1));
        check({tag, "/co"},   CO, last_co);
        check({tag, "/o"},    O, last_o);
        check({tag, "/cout"}, W'(COUT), W'(last_co[W-1]));
    endtask

    task automatic expect_hold(input string tag);
        check({tag, "/vld"}, W'(OUT_VLD), W'(0));
        check({tag, "/co"},  CO, last_co);
        check({tag, "/o"},   O, last_o);
    endtask

    initial begin
`ifdef CARRY_CHAIN_OVF_EN
        OVF_CLR = 1'b0;
`endif
        drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);

        // Reset and idle
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        tick();
        check("rst/vld",  W'(OUT_VLD), W'(0));
        check("rst/co",   CO, 16'h0000);
        check("rst/o",    O, 16'h0000);
        check("rst/cout", W'(COUT), W'(0));

        // Adder 0x00FF + 0x0001
        drive(1'b1, 1'b1, 16'h00FF, 16'h00FE, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        tick();
        check("add/early", W'(OUT_VLD), W'(0));
        tick();
        check("add/vld",  W'(OUT_VLD), W'(1));
        check("add/o",    O, 16'h0100);
        check("add/co",   CO, 16'h00FF);
        check("add/cout", W'(COUT), W'(0));
        last_co = 16'h00FF;
        last_o  = 16'h0100;
        tick();
        expect_hold("add/after");

        // Full propagate through all four stages
        drive(1'b1, 1'b1, 16'h0000, 16'hFFFF, 1'b0, 1'b1);
        tick();
        drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        check("prop/vld",  W'(OUT_VLD), W'(1));
        check("prop/o",    O, 16'h0000);
        check("prop/co",   CO, 16'hFFFF);
        check("prop/cout", W'(COUT), W'(1));
        last_co = 16'hFFFF;
        last_o  = 16'h0000;
        tick();

        // Streaming: b0 b1 b2, 2-cycle CE stall, bubble, b3
        drive(1'b1, 1'b1, 16'h1234, 16'h0F0F, 1'b1, 1'b0);
        tick();
        check("str/c0", W'(OUT_VLD), W'(0));
        drive(1'b1, 1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
        tick();
        check("str/c1", W'(OUT_VLD), W'(0));
        drive(1'b1, 1'b1, 16'h8000, 16'h7FFF, 1'b0, 1'b1);
        tick();
        check("str/c2", W'(OUT_VLD), W'(0));
        drive(1'b0, 1'b1, 16'hDEAD, 16'hBEEF, 1'b1, 1'b1);
        tick();
        expect_hold("str/stall0");
        tick();
        expect_hold("str/stall1");
        drive(1'b1, 1'b0, 16'hDEAD, 16'hBEEF, 1'b1, 1'b0);
        tick();
        expect_beat("str/b0", 16'h1234, 16'h0F0F, 1'b1);
        drive(1'b1, 1'b1, 16'h00F0, 16'hAAAA, 1'b0, 1'b0);
        tick();
        expect_beat("str/b1", 16'hFFFF, 16'h0000, 1'b0);
        drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        expect_beat("str/b2", 16'h8000, 16'h7FFF, 1'b1);
        tick();
        expect_hold("str/bubble");
        tick();
        expect_beat("str/b3", 16'h00F0, 16'hAAAA, 1'b0);
        tick();
        expect_hold("str/tail");

        // Reset mid-flight, asserted while CE is low
        drive(1'b1, 1'b1, 16'h0F0F, 16'hF0F0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b1, 16'h5555, 16'h3333, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        CE  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("flush/vld%0d", i), W'(OUT_VLD), W'(0));
            tick();
        end
        check("flush/co",   CO, 16'h0000);
        check("flush/o",    O, 16'h0000);
        check("flush/cout", W'(COUT), W'(0));

`ifdef CARRY_CHAIN_OVF_EN
        // 0x7FFF + 0x0001 overflows
        drive(1'b1, 1'b1, 16'h7FFF, 16'h7FFE, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        check("ovf1/o",      O, 16'h8000);
        check("ovf1/ovf",    W'(OVF), W'(1));
        check("ovf1/sticky", W'(OVF_STICKY), W'(1));
        // 0x0001 + 0x0001 does not
        drive(1'b1, 1'b1, 16'h0001, 16'h0000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        check("ovf2/o",      O, 16'h0002);
        check("ovf2/ovf",    W'(OVF), W'(0));
        check("ovf2/sticky", W'(OVF_STICKY), W'(1));
        OVF_CLR = 1'b1;
        tick();
        OVF_CLR = 1'b0;
        check("ovfclr/sticky", W'(OVF_STICKY), W'(0));
        check("ovfclr/ovf",    W'(OVF), W'(0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/carry_chain_pipe.md
Name: carry_chain_pipe

Overview:
- Parametrised, pipelined carry chain.
- Computes the same per-bit CO/O function as the 4-bit carry primitive, but over WIDTH bits.
- The chain is split into SEG-bit segments, with one register stage per segment. This breaks the long ripple path for wide adders, comparators and counters on the Verilator/Xilinx models.
- Accepts one operand beat per cycle, has valid tracking and a clock enable, and gives fixed latency NSEG = WIDTH/SEG.

Parameters:
- WIDTH, 32, total chain width in bits; must be a multiple of SEG.
- SEG, 4, bits per pipeline segment; must be 4 or 8 (CARRY4 / CARRY8 granularity). Any illegal WIDTH/SEG combination is an elaboration-time error.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- CE  input  1  clock enable for all pipeline registers.
- IN_VLD  input  1  beat valid on DI/S/CI/CYINIT.
- CI  input  1  carry cascade input.
- CYINIT  input  1  carry init; effective chain input is CI|CYINIT.
- DI  input  WIDTH  carry MUX data inputs.
- S  input  WIDTH  carry MUX selects (propagate).
- OUT_VLD  output  1  result valid.
- CO  output  WIDTH  per-bit carry out.
- O  output  WIDTH  per-bit XOR out.
- COUT  output  1  carry out of bit WIDTH-1 (equal to CO[WIDTH-1]).

Behaviour:
- Function per accepted beat:
  - c0 = CI|CYINIT.
  - CO[i] = S[i] ? c_i : DI[i]; c_{i+1} = CO[i].
  - O[i] = S[i] ^ c_i.
  - Results are bit-identical to a full-width combinational ripple.
- Segment k (k = 0..NSEG-1) covers bits [k*SEG +: SEG].
  - Its carry-in is c0 for k=0.
  - Otherwise its carry-in is the registered carry-out of segment k-1 from the previous stage.
- Input skew: DI/S of segment k are delayed k register stages before use, so segment k evaluates beat t at advance t+k.
- Output deskew: the CO/O of segment k are delayed NSEG-1-k stages, so all segments of one beat reach the output registers together.
- Latency: OUT_VLD rises exactly NSEG enabled clock edges after the edge that samples IN_VLD=1.
  - WIDTH==SEG gives latency 1.
  - Throughput is one beat per enabled cycle; there is no backpressure.
- CE=0: every register, including valid bits and outputs, holds.
- RST=1: all registers clear on the edge, regardless of CE.
  - Reset has priority over CE.
  - After reset: OUT_VLD=0, CO=0, O=0, COUT=0.
  - Beats in flight are discarded and never produce OUT_VLD.
- Bubbles: IN_VLD=0 beats travel as invalid slots.
  - CO/O/COUT registers load only when an enabled edge delivers a valid slot.
  - Otherwise they hold the last valid result; OUT_VLD=0 during that hold.
- Order is preserved, and no beat is dropped or duplicated.
- There is no state machine; behaviour is a shift of valid bits plus data registers.

Optional Feature:
- Macro: CARRY_CHAIN_OVF_EN.
- When defined, adds:
  - input OVF_CLR (1 bit);
  - output OVF (1 bit);
  - output OVF_STICKY (1 bit).
- OVF = CO[WIDTH-1]^CO[WIDTH-2] of the output beat (signed overflow). It is registered with CO/O and holds with them.
- OVF_STICKY is set on any enabled edge delivering a valid beat with overflow.
  - OVF_STICKY is cleared by RST, or by OVF_CLR on an enabled edge.
  - Set wins over a simultaneous OVF_CLR.
- Without the macro, these ports and their logic do not exist.

Decomposition:
- Package carry_pkg contains:
  - localparam defaults (CARRY_SEG_DEF=4);
  - function carry_nseg(WIDTH, SEG);
  - a typedef for the segment result struct {co, o}.
- Sub-module carry_seg: a combinational SEG-bit ripple (inputs ci, di, s; outputs co, o). It is instantiated NSEG times.
- Skew, deskew and valid registers stay in carry_chain_pipe.

Test Plan:
All scenarios use WIDTH=16, SEG=4, latency 4.
- Reset and idle: RST=1 for 2 cycles, then idle → OUT_VLD=0, CO=0x0000, O=0x0000, COUT=0.
- Adder use: A=0x00FF, B=0x0001, S=A^B=0x00FE, DI=A, CI=0, IN_VLD=1 for one cycle → 4 cycles later OUT_VLD=1 for one cycle, O=0x0100, COUT=0.
- Full propagate: S=0xFFFF, DI=0, CYINIT=1 → O=0x0000, CO=0xFFFF, COUT=1. This proves the carry crossing all 4 stages lands on the same beat.
- Streaming with stalls: 3 back-to-back beats, then one bubble, then one beat, with CE=0 for 2 cycles mid-stream.
  - Outputs come out in order, matching a combinational reference model.
  - Each latency is extended by exactly 2.
  - O/CO hold during the bubble.
- Reset mid-flight: 2 beats accepted, then RST at the next edge → OUT_VLD stays 0 for 6 cycles; outputs are 0.
- With CARRY_CHAIN_OVF_EN:
  - 0x7FFF+0x0001 → OVF=1, OVF_STICKY=1.
  - Then 0x0001+0x0001 → OVF=0, OVF_STICKY=1.
  - OVF_CLR pulse → OVF_STICKY=0.
